// File: rtl/adc_spi_responder_pkg.sv
// adc_spi_pkg: shared types and constants for the LTC2308-style SPI responder.
// Holds the FSM state encoding, default geometry and config-word bit positions.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2,
        SHIFT   = 2'd3
    } state_t;

    localparam int CFG_W_DEF       = 6;
    localparam int DATA_W_DEF      = 12;
    localparam int CONV_CYCLES_DEF = 80;

    // Config word bit positions, MSB first on the wire: S/D, O/S, S1, S0, UNI, SLP.
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

endpackage

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: the four-wire ADC SPI link between the scope's master
// and the responder.
// Link semantics: there is no valid/ready pair. A frame is the span where
// adc_cs_n is low; the master changes adc_din on SCLK falling edges and samples
// adc_dout on SCLK rising edges; the responder updates adc_dout after each
// falling edge. adc_cs_n rising closes the frame and starts a conversion.
interface adc_spi_responder_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_din;
    logic adc_dout;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        output adc_din,
        input  adc_dout
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_din,
        output adc_dout
    );
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous input plus one-cycle
// rise/fall pulses derived from the synchronized level.
// RESET_VAL sets the idle level so that reset does not fake an edge.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain plus a history flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC end of the LTC2308-style SPI link. Captures the config
// word on DIN, returns the last conversion result MSB-first on DOUT, and
// samples chan_data for the channel selected by the previous frame's config.
// Optional macro ADC_SPI_RESPONDER_ERRCNT_EN adds err_cnt, a saturating
// protocol-violation counter.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int CONV_CYCLES = CONV_CYCLES_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CFG_W       = CFG_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_spi_responder_if.slave    spi,
    output logic [2:0]            chan_sel,
    input  logic [DATA_W-1:0]     chan_data,
    output logic [CFG_W-1:0]      cfg_word,
    output logic                  busy,
    output logic                  frame_done,
    output state_t                dbg_state
`ifdef ADC_SPI_RESPONDER_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);
    localparam int CONV_W = $clog2(CONV_CYCLES);
    localparam int RC_W   = $clog2(CFG_W + 1);
    localparam int FC_W   = $clog2(DATA_W + 1);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [RC_W-1:0]   RISE_MAX  = RC_W'(CFG_W);
    localparam logic [FC_W-1:0]   FALL_MAX  = FC_W'(DATA_W);
    localparam logic [FC_W-1:0]   FALL_LAST = FC_W'(DATA_W - 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic din_level, din_rise_unused, din_fall_unused;

    state_t              state;
    logic [CONV_W-1:0]   conv_cnt;
    logic [RC_W-1:0]     rise_cnt;
    logic [FC_W-1:0]     fall_cnt;
    logic [DATA_W-1:0]   sr;
    logic [CFG_W-1:0]    cfg_sr;

    // cs_n idles high, so its synchronizer resets high to avoid a false rising edge.
    sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(spi.adc_cs_n),
        .q(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(spi.adc_sclk),
        .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .reset(reset), .d(spi.adc_din),
        .q(din_level), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    assign dbg_state = state;

    // Main FSM: conversion timing, config capture and result shifting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            conv_cnt     <= '0;
            rise_cnt     <= '0;
            fall_cnt     <= '0;
            sr           <= '0;
            cfg_sr       <= '0;
            cfg_word     <= '0;
            chan_sel     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            spi.adc_dout <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_rise) begin
                        state    <= CONVERT;
                        conv_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                CONVERT: begin
                    // All SPI edges are ignored until the result is latched.
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_cnt == CONV_LAST) begin
                        conv_cnt <= '0;
                        sr       <= chan_data;
                        busy     <= 1'b0;
                        if (!cs_level) begin
                            state        <= SHIFT;
                            spi.adc_dout <= chan_data[DATA_W-1];
                            rise_cnt     <= '0;
                            fall_cnt     <= '0;
                        end else begin
                            state        <= READY;
                            spi.adc_dout <= 1'b0;
                        end
                    end
                end
                READY: begin
                    spi.adc_dout <= 1'b0;
                    if (cs_fall) begin
                        state        <= SHIFT;
                        spi.adc_dout <= sr[DATA_W-1];
                        rise_cnt     <= '0;
                        fall_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Frame close wins over any same-cycle SCLK edge.
                        frame_done <= 1'b1;
                        if (rise_cnt == RISE_MAX) begin
                            cfg_word <= cfg_sr;
                            chan_sel <= cfg_sr[CFG_OS:CFG_S0];
                        end
                        state        <= CONVERT;
                        conv_cnt     <= '0;
                        busy         <= 1'b1;
                        spi.adc_dout <= 1'b0;
                    end else begin
                        if (sclk_rise && (rise_cnt < RISE_MAX)) begin
                            cfg_sr   <= {cfg_sr[CFG_W-2:0], din_level};
                            rise_cnt <= rise_cnt + 1'b1;
                        end
                        if (sclk_fall) begin
                            if (fall_cnt < FALL_MAX) begin
                                fall_cnt <= fall_cnt + 1'b1;
                            end
                            if (fall_cnt < FALL_LAST) begin
                                sr           <= {sr[DATA_W-2:0], 1'b0};
                                spi.adc_dout <= sr[DATA_W-2];
                            end else begin
                                spi.adc_dout <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_SPI_RESPONDER_ERRCNT_EN
    logic violation;

    // Any violation in a cycle, however many, counts once.
    always_comb begin
        violation = 1'b0;
        if ((state == CONVERT) && (sclk_rise || sclk_fall || cs_fall)) begin
            violation = 1'b1;
        end
        if ((state == SHIFT) && cs_rise && (rise_cnt < RISE_MAX)) begin
            violation = 1'b1;
        end
    end

    // Saturating violation counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 8'd0;
        end else if (violation && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
